// File: rtl/ntm_write_heads_demux.sv
// ntm_write_heads_demux
//
// Write-head front end for the DNC/NTM datapath. It takes the write part of
// the controller interface vector as a stream of words and splits it, per
// write head, into the fields k, beta, e, v, ga and gw. Every accepted word
// comes out one registered stage later with exactly one field strobe, the
// index of its head and its element index within the field. The vector
// length and head count are latched at START and clipped to W and H.
//
// Per-head word order: k[0..sw-1], beta, e[0..sw-1], v[0..sw-1], ga, gw.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   START / READY            begin a transfer / one-cycle pulse with final gw
//   SIZE_W_IN, SIZE_H_IN     vector length and head count, latched at START
//   XI_IN_ENABLE, XI_IN      input word stream; a word is accepted when the
//                            enable is high and the block is not idle
//   *_OUT_ENABLE             field strobes: K, BETA, E, V, GA, GW
//   DATA_OUT                 the word qualified by the active strobe
//   HEAD_OUT, INDEX_OUT      head index and element index of DATA_OUT
//   DEBUG_STATE              current FSM state (IDLE = 0)
//
// Handshake: XI_IN_ENABLE is a valid-only strobe with no backpressure. The
// block accepts every valid word while a transfer is in progress, and a
// cycle without valid stalls the FSM for as long as needed. Valid is
// ignored while idle. Output strobes are one-cycle valids with no ready.

module ntm_write_heads_demux #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int W            = 64,
    parameter int H            = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [DATA_SIZE-1:0]    SIZE_W_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_H_IN,
    input  logic                    XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    XI_IN,
    output logic                    K_OUT_ENABLE,
    output logic                    BETA_OUT_ENABLE,
    output logic                    E_OUT_ENABLE,
    output logic                    V_OUT_ENABLE,
    output logic                    GA_OUT_ENABLE,
    output logic                    GW_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic [CONTROL_SIZE-1:0] HEAD_OUT,
    output logic [CONTROL_SIZE-1:0] INDEX_OUT,
    output logic [2:0]              DEBUG_STATE
);

    // Widths hold the values W and H themselves, not only W-1 and H-1.
    localparam int WW = $clog2(W + 1);
    localparam int HW = $clog2(H + 1);

    // Bit positions in the one-hot field vector.
    localparam int F_K    = 0;
    localparam int F_BETA = 1;
    localparam int F_E    = 2;
    localparam int F_V    = 3;
    localparam int F_GA   = 4;
    localparam int F_GW   = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY      = 3'd1,
        S_STRENGTH = 3'd2,
        S_ERASE    = 3'd3,
        S_VECTOR   = 3'd4,
        S_ALLOC    = 3'd5,
        S_WGATE    = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] sw, sw_clip;
    logic [HW-1:0] sh, sh_clip;
    logic [HW-1:0] h, h_n;
    logic [WW-1:0] j, j_n;
    logic [5:0]    field_n;
    logic          ready_n;
    logic          last_elem;
    logic          last_head;

    // Size clipping, applied at the moment START is taken.
    assign sw_clip = (SIZE_W_IN > DATA_SIZE'(W)) ? WW'(W) : WW'(SIZE_W_IN);
    assign sh_clip = (SIZE_H_IN > DATA_SIZE'(H)) ? HW'(H) : HW'(SIZE_H_IN);

    // Written as an increment-and-compare so that sw = 0 cannot underflow.
    assign last_elem = (WW'(j + WW'(1)) == sw);
    assign last_head = (HW'(h + HW'(1)) == sh);

    assign DEBUG_STATE = state;

    always_comb begin
        state_n = state;
        h_n     = h;
        j_n     = j;
        field_n = '0;
        ready_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    h_n = '0;
                    j_n = '0;
                    if (sh_clip == '0) begin
                        // Nothing to move: finish at once and stay idle.
                        ready_n = 1'b1;
                    end else if (sw_clip == '0) begin
                        state_n = S_STRENGTH;
                    end else begin
                        state_n = S_KEY;
                    end
                end
            end
            S_KEY: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_K] = 1'b1;
                    if (last_elem) begin
                        state_n = S_STRENGTH;
                        j_n     = '0;
                    end else begin
                        j_n = WW'(j + WW'(1));
                    end
                end
            end
            S_STRENGTH: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_BETA] = 1'b1;
                    j_n             = '0;
                    state_n         = (sw == '0) ? S_ALLOC : S_ERASE;
                end
            end
            S_ERASE: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_E] = 1'b1;
                    if (last_elem) begin
                        state_n = S_VECTOR;
                        j_n     = '0;
                    end else begin
                        j_n = WW'(j + WW'(1));
                    end
                end
            end
            S_VECTOR: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_V] = 1'b1;
                    if (last_elem) begin
                        state_n = S_ALLOC;
                        j_n     = '0;
                    end else begin
                        j_n = WW'(j + WW'(1));
                    end
                end
            end
            S_ALLOC: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_GA] = 1'b1;
                    j_n           = '0;
                    state_n       = S_WGATE;
                end
            end
            S_WGATE: begin
                if (XI_IN_ENABLE) begin
                    field_n[F_GW] = 1'b1;
                    j_n           = '0;
                    if (last_head) begin
                        ready_n = 1'b1;
                        h_n     = '0;
                        state_n = S_IDLE;
                    end else begin
                        h_n     = HW'(h + HW'(1));
                        state_n = (sw == '0) ? S_STRENGTH : S_KEY;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                h_n     = '0;
                j_n     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            h     <= '0;
            j     <= '0;
            sw    <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            h     <= h_n;
            j     <= j_n;
            if (state == S_IDLE && START) begin
                sw <= sw_clip;
                sh <= sh_clip;
            end
        end
    end

    // Output stage: strobes follow the accepted word; data, head and index
    // only update with a strobe and otherwise hold their last value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            K_OUT_ENABLE    <= 1'b0;
            BETA_OUT_ENABLE <= 1'b0;
            E_OUT_ENABLE    <= 1'b0;
            V_OUT_ENABLE    <= 1'b0;
            GA_OUT_ENABLE   <= 1'b0;
            GW_OUT_ENABLE   <= 1'b0;
            READY           <= 1'b0;
            DATA_OUT        <= '0;
            HEAD_OUT        <= '0;
            INDEX_OUT       <= '0;
        end else begin
            K_OUT_ENABLE    <= field_n[F_K];
            BETA_OUT_ENABLE <= field_n[F_BETA];
            E_OUT_ENABLE    <= field_n[F_E];
            V_OUT_ENABLE    <= field_n[F_V];
            GA_OUT_ENABLE   <= field_n[F_GA];
            GW_OUT_ENABLE   <= field_n[F_GW];
            READY           <= ready_n;
            if (|field_n) begin
                DATA_OUT  <= XI_IN;
                HEAD_OUT  <= CONTROL_SIZE'(h);
                // j is already 0 in the scalar states.
                INDEX_OUT <= CONTROL_SIZE'(j);
            end
        end
    end

endmodule
